// File: rtl/game_state_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// game_state_ctrl_pkg
// Shared definitions for the two-player ship game. The game controller and
// the placement-permission block both import this package.
//   - game_state_t : encoding of the game phase.
//   - winner_t     : encoding of the winner output.
//   - default fleet size and the number of hits needed to win.
//   - other_turn() : returns the opposing player's turn state.
// ---------------------------------------------------------------------------
package game_state_ctrl_pkg;

   localparam int NUM_SHIPS_DEF   = 5;
   localparam int HITS_TO_WIN_DEF = 17;   // 5+4+3+3+2 ship cells
   localparam int IDX_W           = 3;
   localparam int HIT_W           = 5;

   typedef enum logic [2:0] {
      P1_PLACE  = 3'd0,
      P2_PLACE  = 3'd1,
      P1_TURN   = 3'd2,
      P2_TURN   = 3'd3,
      GAME_OVER = 3'd4
   } game_state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10
   } winner_t;

   function automatic game_state_t other_turn(input game_state_t s);
      return (s == P1_TURN) ? P2_TURN : P1_TURN;
   endfunction

endpackage

// File: rtl/game_state_ctrl_hit_counter.sv
// ---------------------------------------------------------------------------
// hit_counter
// Saturating hit counter for one player.
//   clk    : system clock
//   reset  : synchronous active-high reset, clears the count
//   clr    : synchronous clear (new game / illegal-state recovery)
//   inc    : add one hit; ignored once the count reaches MAX
//   count  : current number of hits (registered)
// ---------------------------------------------------------------------------
module hit_counter
   import game_state_ctrl_pkg::*;
#(
   parameter int MAX = HITS_TO_WIN_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [HIT_W-1:0] count
);

   localparam logic [HIT_W-1:0] CNT_MAX = HIT_W'(MAX);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && (count < CNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
// Top-level game controller: ship placement for both players, alternating
// turns, hit counting and winner detection.
//   clk       : system clock, all state changes on the rising edge
//   reset     : synchronous active-high reset, highest priority
//   place_req : strobe, current player confirms a ship placement
//   place_ok  : placement is legal (sampled with place_req)
//   fire_req  : strobe, current player fires
//   shot_hit  : the shot hit an enemy ship (sampled with fire_req)
//   new_game  : strobe, restart from GAME_OVER
//   state     : game state (see game_state_t)
//   ship_idx  : index of the ship currently being placed
//   p1_hits   : hits scored by player 1
//   p2_hits   : hits scored by player 2
//   winner    : 00 none, 01 player 1, 10 player 2
//   place_err : one-cycle pulse for a rejected placement
// ---------------------------------------------------------------------------
module game_state_ctrl
   import game_state_ctrl_pkg::*;
#(
   parameter int NUM_SHIPS   = NUM_SHIPS_DEF,
   parameter int HITS_TO_WIN = HITS_TO_WIN_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             place_req,
   input  logic             place_ok,
   input  logic             fire_req,
   input  logic             shot_hit,
   input  logic             new_game,
   output logic [2:0]       state,
   output logic [IDX_W-1:0] ship_idx,
   output logic [HIT_W-1:0] p1_hits,
   output logic [HIT_W-1:0] p2_hits,
   output logic [1:0]       winner,
   output logic             place_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SHIPS - 1);
   localparam logic [HIT_W-1:0] WIN_PREV = HIT_W'(HITS_TO_WIN - 1);

   game_state_t      state_q;
   winner_t          winner_q;
   logic             illegal_state;
   logic             p1_inc;
   logic             p2_inc;
   logic             hits_clr;
   logic [HIT_W-1:0] shooter_hits;
   logic             winning_shot;

   // Values 5..7 are not in the enum but can appear after an upset; they are
   // detected explicitly so the counters can be cleared alongside recovery.
   assign illegal_state = (state_q != P1_PLACE) && (state_q != P2_PLACE) &&
                          (state_q != P1_TURN)  && (state_q != P2_TURN)  &&
                          (state_q != GAME_OVER);

   assign p1_inc   = (state_q == P1_TURN) && fire_req && shot_hit;
   assign p2_inc   = (state_q == P2_TURN) && fire_req && shot_hit;
   assign hits_clr = ((state_q == GAME_OVER) && new_game) || illegal_state;

   assign shooter_hits = (state_q == P1_TURN) ? p1_hits : p2_hits;
   assign winning_shot = fire_req && shot_hit && (shooter_hits == WIN_PREV);

   hit_counter #(
      .MAX   (HITS_TO_WIN)
   ) u_p1_hits (
      .clk   (clk),
      .reset (reset),
      .clr   (hits_clr),
      .inc   (p1_inc),
      .count (p1_hits)
   );

   hit_counter #(
      .MAX   (HITS_TO_WIN)
   ) u_p2_hits (
      .clk   (clk),
      .reset (reset),
      .clr   (hits_clr),
      .inc   (p2_inc),
      .count (p2_hits)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= P1_PLACE;
         ship_idx  <= '0;
         winner_q  <= WIN_NONE;
         place_err <= 1'b0;
      end else begin
         place_err <= 1'b0;
         case (state_q)
            P1_PLACE, P2_PLACE: begin
               // fire_req and new_game are meaningless while placing
               if (place_req) begin
                  if (!place_ok) begin
                     place_err <= 1'b1;
                  end else if (ship_idx == LAST_IDX) begin
                     ship_idx <= '0;
                     state_q  <= (state_q == P1_PLACE) ? P2_PLACE : P1_TURN;
                  end else begin
                     ship_idx <= ship_idx + 1'b1;
                  end
               end
            end
            P1_TURN, P2_TURN: begin
               // a winning shot ends the game without handing over the turn
               if (fire_req) begin
                  if (winning_shot) begin
                     state_q  <= GAME_OVER;
                     winner_q <= (state_q == P1_TURN) ? WIN_P1 : WIN_P2;
                  end else begin
                     state_q  <= other_turn(state_q);
                  end
               end
            end
            GAME_OVER: begin
               if (new_game) begin
                  state_q  <= P1_PLACE;
                  ship_idx <= '0;
                  winner_q <= WIN_NONE;
               end
            end
            default: begin
               state_q  <= P1_PLACE;
               ship_idx <= '0;
               winner_q <= WIN_NONE;
            end
         endcase
      end
   end

   assign state  = state_q;
   assign winner = winner_q;

endmodule
